ram_bus_master: RTL

Initiator-side controller for the single-port synchronous RAM bus (addr / bidirectional data / chip_select / write_enable / output_enable).
- Accepts one read or write request at a time on a valid/ready request port.
- Sequences the RAM control pins with correct cycle timing and owns the tristate data bus.
- Returns read data or a write acknowledge on a valid/ready response port.
- Sits between the CPU datapath / load-store unit and the banked large RAM.

---
 rtl/ram_bus_pkg.sv | 38 +++
 rtl/ram_bus_tristate.sv | 45 ++++
 rtl/ram_bus_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the single-port RAM bus initiator.
package ram_bus_pkg;

   localparam int RB_ADDR_WIDTH    = 14;
   localparam int RB_DATA_WIDTH    = 16;
   localparam int MAX_READ_LATENCY = 7;
   localparam int CNT_WIDTH        = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_ADDR = 3'd2,
      RD_WAIT = 3'd3,
      RESP    = 3'd4
   } state_e;

   // Request as latched at acceptance; field widths follow the default bus widths.
   typedef struct packed {
      logic                     write;
      logic [RB_ADDR_WIDTH-1:0] addr;
      logic [RB_DATA_WIDTH-1:0] wdata;
   } req_t;

   // Counter load value for the read wait phase; latency is clamped into 1..MAX.
   function automatic logic [CNT_WIDTH-1:0] wait_load(input int latency);
      int lat;
      lat = latency;
      if (lat < 1) begin
         lat = 1;
      end else if (lat > MAX_READ_LATENCY) begin
         lat = MAX_READ_LATENCY;
      end else begin
         lat = latency;
      end
      return CNT_WIDTH'(lat - 1);
   endfunction

endpackage

// File: rtl/ram_bus_tristate.sv
// Owns the RAM data bus driver and the read-data capture register.
module ram_bus_tristate
   import ram_bus_pkg::*;
#(
   parameter int DATA_WIDTH = RB_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drive_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  clear_i,
   input  logic                  capture_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   inout  wire  [DATA_WIDTH-1:0] mem_data_io
);

   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   // drive_i and wdata_i are both registered, so the bus never glitches from inputs
   assign mem_data_io = drive_i ? wdata_i : {DATA_WIDTH{1'bz}};
   assign rdata_o     = rdata_q;

   // Next value of the response data: cleared on a new request, loaded on capture
   always_comb begin
      rdata_d = rdata_q;
      if (clear_i) begin
         rdata_d = {DATA_WIDTH{1'b0}};
      end else if (capture_i) begin
         rdata_d = mem_data_io;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Response data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: rtl/ram_bus_master.sv
// Initiator-side sequencer for the single-port synchronous RAM bus.
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int ADDR_WIDTH   = RB_ADDR_WIDTH,
   parameter int DATA_WIDTH   = RB_DATA_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   req_t                   req_q, req_d;
   logic                   clear_s, capture_s;

   // Output registers, loaded from the decode of the next state
   logic req_ready_q, req_ready_d;
   logic rsp_valid_q, rsp_valid_d;
   logic rsp_write_q, rsp_write_d;
   logic mem_cs_q, mem_cs_d;
   logic mem_we_q, mem_we_d;
   logic mem_oe_q, mem_oe_d;
   logic drive_q, drive_d;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_oe    = mem_oe_q;
   assign mem_addr  = req_q.addr;

   // Next-state logic: request latch, read wait counter and capture strobe
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      clear_s   = 1'b0;
      capture_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               req_d.write = req_write;
               req_d.addr  = req_addr;
               req_d.wdata = req_wdata;
               clear_s     = 1'b1;
               state_d     = req_write ? WR : RD_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            state_d = RESP;
         end
         RD_ADDR: begin
            cnt_d   = wait_load(READ_LATENCY);
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt_q == {CNT_WIDTH{1'b0}}) begin
               capture_s = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decode of the bus controls for the state being entered
   always_comb begin
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_write_d = 1'b0;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_oe_d    = 1'b0;
      drive_d     = 1'b0;
      case (state_d)
         IDLE: begin
            req_ready_d = 1'b1;
         end
         WR: begin
            mem_cs_d = 1'b1;
            mem_we_d = 1'b1;
            drive_d  = 1'b1;
         end
         RD_ADDR, RD_WAIT: begin
            mem_cs_d = 1'b1;
            mem_oe_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = req_d.write;
         end
         default: begin
            req_ready_d = 1'b0;
         end
      endcase
   end

   // State, counter, request and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_WIDTH{1'b0}};
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_oe_q    <= 1'b0;
         drive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_oe_q    <= mem_oe_d;
         drive_q     <= drive_d;
      end
   end

   ram_bus_tristate #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tristate (
      .clk         (clk),
      .rst_n       (rst_n),
      .drive_i     (drive_q),
      .wdata_i     (req_q.wdata),
      .clear_i     (clear_s),
      .capture_i   (capture_s),
      .rdata_o     (rsp_rdata),
      .mem_data_io (mem_data)
   );

endmodule
